// File: rtl/mbrtu_rx_fsm_if.sv
// Modbus RTU receive framer bus: UART byte strobe in, frame ack and
// buffer read port in; event strobe/code, frame status, drop count out.
interface mbrtu_rx_fsm_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_err;
  logic       frame_ack;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       event_post;
  logic [1:0] event_code;
  logic [8:0] frame_len;
  logic       frame_lock;
  logic [7:0] drop_cnt;

  modport master (
    output rx_valid, rx_byte, rx_err,
    output frame_ack, rd_addr,
    input  rd_data, event_post, event_code,
    input  frame_len, frame_lock, drop_cnt
  );

  modport slave (
    input  rx_valid, rx_byte, rx_err,
    input  frame_ack, rd_addr,
    output rd_data, event_post, event_code,
    output frame_len, frame_lock, drop_cnt
  );
endinterface

// File: rtl/mbrtu_rx_fsm.sv
// Modbus RTU receive framer: silence-delimited frames into a buffer.
// Ports: clk, rst (sync, active-high), bus (slave side of the framer bus).
module mbrtu_rx_fsm #(
  parameter int T15_CYCLES = 750,
  parameter int T35_CYCLES = 1750,
  parameter int MAX_LEN    = 256
) (
  input logic          clk,
  input logic          rst,
  mbrtu_rx_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RCV,
    ERROR
  } state_t;

  localparam logic [15:0] T15  = 16'(T15_CYCLES);
  localparam logic [15:0] T35  = 16'(T35_CYCLES);
  localparam logic [8:0]  MAXL = 9'(MAX_LEN);

  state_t      state;
  logic [15:0] silCnt;
  logic        t35Seen;
  logic [8:0]  len;

  logic        postQ;
  logic [1:0]  codeQ;
  logic [8:0]  lenOutQ;
  logic        lockQ;
  logic [7:0]  dropQ;
  logic [7:0]  rdQ;

  logic [7:0]  mem [MAX_LEN];

  logic        t35Hit;
  logic        gapViol;
  logic        wrEn;
  logic [7:0]  wrAddr;
  logic        dropInc;

  // t35Seen stops the saturated counter from re-firing the expiry.
  assign t35Hit  = (silCnt == T35) && !t35Seen;
  // A byte landing exactly on the expiry cycle still belongs to the frame.
  assign gapViol = (silCnt >= T15) && !t35Hit;

  always_comb begin
    wrEn   = 1'b0;
    wrAddr = 8'd0;
    if (bus.rx_valid && !bus.rx_err) begin
      if (state == IDLE &&
          (!lockQ || bus.frame_ack)) begin
        wrEn   = 1'b1;
        wrAddr = 8'd0;
      end else if (state == RCV &&
                   !gapViol &&
                   len < MAXL) begin
        wrEn   = 1'b1;
        wrAddr = len[7:0];
      end
    end
  end

  // Every byte not stored is a discarded byte.
  assign dropInc = bus.rx_valid && !wrEn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      silCnt  <= 16'd0;
      t35Seen <= 1'b0;
      len     <= 9'd0;
      postQ   <= 1'b0;
      codeQ   <= 2'd0;
      lenOutQ <= 9'd0;
      lockQ   <= 1'b0;
      dropQ   <= 8'd0;
    end else begin
      postQ <= 1'b0;

      if (bus.rx_valid) begin
        silCnt  <= 16'd0;
        t35Seen <= 1'b0;
      end else begin
        if (silCnt != T35)
          silCnt <= silCnt + 16'd1;
        t35Seen <= (silCnt == T35);
      end

      if (dropInc && dropQ != 8'hFF)
        dropQ <= dropQ + 8'd1;

      if (bus.frame_ack)
        lockQ <= 1'b0;

      unique case (state)
        INIT: begin
          if (!bus.rx_valid && t35Hit) begin
            postQ <= 1'b1;
            codeQ <= 2'd0;
            state <= IDLE;
          end
        end
        IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_err) begin
              state <= ERROR;
            end else if (wrEn) begin
              len   <= 9'd1;
              state <= RCV;
            end
          end
        end
        RCV: begin
          if (bus.rx_valid) begin
            if (wrEn)
              len <= len + 9'd1;
            else
              state <= ERROR;
          end else if (t35Hit) begin
            lenOutQ <= len;
            lockQ   <= 1'b1;
            postQ   <= 1'b1;
            codeQ   <= 2'd1;
            state   <= IDLE;
          end
        end
        ERROR: begin
          if (!bus.rx_valid && t35Hit)
            state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn)
      mem[wrAddr] <= bus.rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rdQ <= 8'd0;
    else
      rdQ <= mem[bus.rd_addr];
  end

  assign bus.rd_data    = rdQ;
  assign bus.event_post = postQ;
  assign bus.event_code = codeQ;
  assign bus.frame_len  = lenOutQ;
  assign bus.frame_lock = lockQ;
  assign bus.drop_cnt   = dropQ;

endmodule

// File: doc/mbrtu_rx_fsm.md
MBRTU_RX_FSM -- requirements
Module: mbrtu_rx_fsm

Purpose: Modbus RTU receive framer. It delimits frames by inter-character silence, buffers the bytes and posts events to the port event queue, which sits downstream.

Interface
REQ-001 Parameters (name, default, meaning):
- T15_CYCLES, 750: clk cycles of silence marking the 1.5-character gap.
- T35_CYCLES, 1750: clk cycles of silence marking the 3.5-character gap (frame end); SHALL be greater than T15_CYCLES.
- MAX_LEN, 256: frame buffer depth in bytes.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- rx_valid, in, 1: one-cycle strobe; a UART byte is present.
- rx_byte, in, 8: received byte; qualified by rx_valid.
- rx_err, in, 1: parity/framing error on the current byte; qualified by rx_valid.
- frame_ack, in, 1: the poll engine has consumed the frame; releases the buffer.
- rd_addr, in, 8: buffer read address.
- rd_data, out, 8: buffer read data, registered.
- event_post, out, 1: one-cycle event strobe to the event queue.
- event_code, out, 2: event code; 0 = EV_READY, 1 = EV_FRAME_RECEIVED.
- frame_len, out, 9: length of the locked frame in bytes, 1..256.
- frame_lock, out, 1: a received frame is held awaiting frame_ack.
- drop_cnt, out, 8: saturating count of bytes discarded.

Function
REQ-004 States: INIT, IDLE, RCV, ERROR.
REQ-005 Silence counter (16-bit):
- Clears to 0 in any cycle with rx_valid = 1.
- Otherwise increments each cycle and saturates at T35_CYCLES.
- t35_hit is a one-cycle pulse in the cycle the counter first equals T35_CYCLES.
REQ-006 rx_valid and t35_hit in the same cycle: the byte wins; the counter clears and no expiry is acted on.
REQ-007 INIT: on t35_hit, post EV_READY and go to IDLE. Bytes received in INIT are discarded, increment drop_cnt and restart the counter.
REQ-008 IDLE with rx_valid, rx_err = 0 and frame_lock = 0: write the byte to buffer[0], set the internal length to 1, go to RCV.
REQ-009 IDLE with rx_valid and rx_err = 1: go to ERROR; increment drop_cnt.
REQ-010 RCV with rx_valid, rx_err = 0, counter < T15_CYCLES and length < MAX_LEN: write the byte to buffer[length], then increment length.
REQ-011 RCV goes to ERROR when rx_valid arrives with any of:
- rx_err = 1;
- counter >= T15_CYCLES (gap violation);
- length = MAX_LEN (overflow).
The offending byte is discarded and drop_cnt increments.
REQ-012 RCV with t35_hit: latch frame_len = length, set frame_lock, post EV_FRAME_RECEIVED, go to IDLE.
REQ-013 ERROR:
- Each byte is discarded, increments drop_cnt and restarts the counter.
- t35_hit goes to IDLE with no event posted.
REQ-014 While frame_lock = 1:
- Bytes arriving in IDLE are discarded and increment drop_cnt.
- The state stays IDLE and the buffer is not written.
REQ-015 frame_ack clears frame_lock on the next edge. frame_ack while frame_lock = 0 is ignored.
REQ-016 frame_ack and rx_valid in the same cycle in IDLE: the lock clears and the byte is accepted as in REQ-008.
REQ-017 event_post and event_code are registered and assert on the clock edge following t35_hit. event_post is high for exactly one cycle. event_code holds its value until the next post.
REQ-018 rd_data = buffer[rd_addr] one cycle after rd_addr is presented. Reads never alter state.
REQ-019 drop_cnt saturates at 255.

Reset
REQ-020 Synchronous rst SHALL set:
- state = INIT, counter = 0;
- event_post = 0, event_code = 0;
- frame_len = 0, frame_lock = 0, drop_cnt = 0;
- rd_data = 0.
Buffer contents are not reset.
REQ-021 rst asserted mid-frame SHALL abandon the frame: no event is posted and the state returns to INIT.

Verification
Bench parameters: T15_CYCLES = 4, T35_CYCLES = 10, MAX_LEN = 256.
REQ-022 Startup: release rst, keep the line silent.
-> At cycle 10 after release, event_post = 1 with event_code = 0, once only.
REQ-023 Normal frame: send bytes 0x01, 0x03, 0x00 two cycles apart, then silence.
-> event_code = 1, frame_len = 3, frame_lock = 1.
-> Reading rd_addr 0..2 returns 01, 03, 00.
REQ-024 Gap violation: after 0x11, wait 5 cycles, send 0x22, then silence.
-> No event posted, drop_cnt = 1, state returns to IDLE.
REQ-025 Overflow: send 257 bytes one cycle apart.
-> Byte 257 causes ERROR and drop_cnt = 1; no event posted after silence.
REQ-026 Lock: while frame_lock = 1, send 0x55.
-> The byte is dropped and drop_cnt increments.
-> Then send frame_ack together with 0x66: the lock clears, 0x66 is stored at buffer[0], and the block enters RCV.
REQ-027 Collision: rx_valid in the same cycle as the counter reaching 10.
-> No event is posted and the byte is appended to the frame.
